// File: rtl/bram_read_arbiter_pkg.sv
// rtl/bram_read_arbiter_pkg.sv - shared types and constants for the BRAM read arbiter
// FSM encoding, requester IDs and timeout defaults used by the arbiter and its grant logic.
package bram_read_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    localparam logic REQ_AES = 1'b0;
    localparam logic REQ_AUX = 1'b1;

    localparam int DEFAULT_TIMEOUT_CYC = 1024;

    // Counter must be able to hold the value TIMEOUT_CYC itself.
    function automatic int timeout_cnt_width(input int timeout_cyc);
        return $clog2(timeout_cyc + 1);
    endfunction

endpackage

// File: rtl/bram_read_arbiter_if.sv
// rtl/bram_read_arbiter_if.sv - requester, BRAM reader and status bundle for the arbiter
// master is the arbiter view; slave is the view of the surrounding requesters and BRAM reader.
interface bram_read_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              req0_start_read;
    logic [ADDR_W-1:0] req0_addr;
    logic              req0_complete;
    logic [DATA_W-1:0] req0_read_data;

    logic              req1_start_read;
    logic [ADDR_W-1:0] req1_addr;
    logic              req1_complete;
    logic [DATA_W-1:0] req1_read_data;

    logic              bram_start_read;
    logic [ADDR_W-1:0] bram_addr;
    logic              bram_complete;
    logic [DATA_W-1:0] bram_read_data;

    logic              grant_id;
    logic              arb_busy;
    logic              timeout_err;

    modport master (
        input  req0_start_read, req0_addr,
        input  req1_start_read, req1_addr,
        input  bram_complete, bram_read_data,
        output req0_complete, req0_read_data,
        output req1_complete, req1_read_data,
        output bram_start_read, bram_addr,
        output grant_id, arb_busy, timeout_err
    );

    modport slave (
        output req0_start_read, req0_addr,
        output req1_start_read, req1_addr,
        output bram_complete, bram_read_data,
        input  req0_complete, req0_read_data,
        input  req1_complete, req1_read_data,
        input  bram_start_read, bram_addr,
        input  grant_id, arb_busy, timeout_err
    );

endinterface

// File: rtl/bram_read_arbiter_rr_arbiter2.sv
// rtl/bram_read_arbiter_rr_arbiter2.sv - two-way round-robin grant with last-grant pointer
// A lone requester always wins; on a tie the requester not granted last wins.
module rr_arbiter2
    import bram_read_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic       valid_o,
    output logic       grant_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        valid_o = |req_i;
        if (req_i == 2'b11) begin
            grant_o = ~last_q;
        end else begin
            grant_o = req_i[1];
        end
    end

    always_comb begin
        last_d = last_q;
        if (advance_i && valid_o) begin
            last_d = grant_o;
        end
    end

    // Pointer starts at AUX so that AES wins the first tie after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= REQ_AUX;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/bram_read_arbiter.sv
// rtl/bram_read_arbiter.sv - shares one BRAM reader between two requesters
// IDLE arbitrates, ISSUE/WAIT hold the BRAM request, RELEASE swallows stale requests.
module bram_read_arbiter
    import bram_read_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic                 aes_clk,
    input  logic                 aes_rst_n,
    bram_read_arbiter_if.master  bus
);

    localparam int               CNT_W   = timeout_cnt_width(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

    arb_state_t        state_q, state_d;
    logic              grant_q, grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              cmpl0_q, cmpl0_d;
    logic              cmpl1_q, cmpl1_d;
    logic              tout_q, tout_d;

    logic              arb_valid;
    logic              arb_grant;
    logic [CNT_W-1:0]  cnt_inc;
    logic              finish;
    logic [DATA_W-1:0] fin_data;

    rr_arbiter2 u_rr (
        .clk       (aes_clk),
        .rst_n     (aes_rst_n),
        .req_i     ({bus.req1_start_read, bus.req0_start_read}),
        .advance_i (state_q == ST_IDLE),
        .valid_o   (arb_valid),
        .grant_o   (arb_grant)
    );

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        cmpl0_d  = 1'b0;
        cmpl1_d  = 1'b0;
        tout_d   = 1'b0;
        finish   = 1'b0;
        fin_data = '0;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_d = ST_ISSUE;
                    grant_d = arb_grant;
                    addr_d  = (arb_grant == REQ_AUX) ? bus.req1_addr : bus.req0_addr;
                    cnt_d   = '0;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_inc;
                // A completion in the final WAIT cycle beats the timeout.
                if (bus.bram_complete) begin
                    finish   = 1'b1;
                    fin_data = bus.bram_read_data;
                end else if (cnt_inc == CNT_MAX) begin
                    finish = 1'b1;
                    tout_d = 1'b1;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (finish) begin
            state_d = ST_RELEASE;
            if (grant_q == REQ_AUX) begin
                rdata1_d = fin_data;
                cmpl1_d  = 1'b1;
            end else begin
                rdata0_d = fin_data;
                cmpl0_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge aes_clk or negedge aes_rst_n) begin
        if (!aes_rst_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= REQ_AES;
            addr_q   <= '0;
            cnt_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            cmpl0_q  <= 1'b0;
            cmpl1_q  <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            cmpl0_q  <= cmpl0_d;
            cmpl1_q  <= cmpl1_d;
            tout_q   <= tout_d;
        end
    end

    assign bus.bram_start_read = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign bus.bram_addr       = addr_q;
    assign bus.arb_busy        = (state_q != ST_IDLE);
    assign bus.grant_id        = grant_q;
    assign bus.timeout_err     = tout_q;
    assign bus.req0_complete   = cmpl0_q;
    assign bus.req0_read_data  = rdata0_q;
    assign bus.req1_complete   = cmpl1_q;
    assign bus.req1_read_data  = rdata1_q;

    a_cmpl_excl: assert property (@(posedge aes_clk) disable iff (!aes_rst_n)
        !(cmpl0_q && cmpl1_q));

    a_tout_cmpl: assert property (@(posedge aes_clk) disable iff (!aes_rst_n)
        tout_q |-> (cmpl0_q || cmpl1_q));

endmodule

// File: tb/tb_bram_read_arbiter.sv
// tb/tb_bram_read_arbiter.sv - directed self-checking bench for bram_read_arbiter
module tb_bram_read_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int checks    = 0;
    int errors    = 0;
    int issues    = 0;
    int c0_cnt    = 0;
    int c1_cnt    = 0;
    int tout_cnt  = 0;
    int excl_viol = 0;
    logic prev_bsr = 1'b0;

    bram_read_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    bram_read_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (8)
    ) dut (
        .aes_clk   (clk),
        .aes_rst_n (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.bram_start_read && !prev_bsr) issues++;
        prev_bsr = bus.bram_start_read;
        if (bus.req0_complete) c0_cnt++;
        if (bus.req1_complete) c1_cnt++;
        if (bus.timeout_err) tout_cnt++;
        if (bus.req0_complete && bus.req1_complete) excl_viol++;
    end

    // Waits for ISSUE, answers on WAIT cycle `lat` (if respond), returns at the complete-pulse negedge.
    task automatic serve(input int lat, input logic [31:0] data, input bit respond,
                         output int wait_cyc, output int k_done);
        wait_cyc = -1;
        k_done   = -1;
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            if (bus.bram_start_read) begin
                wait_cyc = t;
                break;
            end
        end
        if (wait_cyc < 0) begin
            check("issue_seen", bus.bram_start_read, 1);
            return;
        end
        for (int k = 0; k <= 40; k++) begin
            if (k > 0 && (bus.req0_complete || bus.req1_complete)) begin
                k_done = k;
                break;
            end
            bus.bram_complete  = respond && (k == lat);
            bus.bram_read_data = (respond && k == lat) ? data : (32'hBAD0_0000 | 32'(k));
            @(negedge clk);
        end
        bus.bram_complete = 1'b0;
        if (k_done < 0) check("done_seen", bus.req0_complete | bus.req1_complete, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int kd;
        int iss0;
        int c00;
        int csum;

        bus.req0_start_read = 1'b0;
        bus.req0_addr       = '0;
        bus.req1_start_read = 1'b0;
        bus.req1_addr       = '0;
        bus.bram_complete   = 1'b0;
        bus.bram_read_data  = '0;

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ctrl", {bus.bram_start_read, bus.arb_busy, bus.timeout_err,
                           bus.req0_complete, bus.req1_complete, bus.grant_id}, 6'b0);
        check("rst_addr", bus.bram_addr, 0);
        check("rst_rd0", bus.req0_read_data, 0);
        check("rst_rd1", bus.req1_read_data, 0);

        // Tie on both requesters, held high throughout: expect 0,1,0,1
        rst_n = 1'b1;
        bus.req0_addr = 32'h10;
        bus.req1_addr = 32'h20;
        bus.req0_start_read = 1'b1;
        bus.req1_start_read = 1'b1;
        for (int i = 0; i < 4; i++) begin
            serve(2, 32'h1111_0000 + 32'(i), 1'b1, w, kd);
            if (i == 0) check("tie_lat", w, 1);
            check($sformatf("tie%0d_grant", i), bus.grant_id, i % 2);
            check($sformatf("tie%0d_addr", i), bus.bram_addr, (i % 2) ? 32'h20 : 32'h10);
            check($sformatf("tie%0d_cmpl", i), {bus.req1_complete, bus.req0_complete},
                  (i % 2) ? 2'b10 : 2'b01);
            check($sformatf("tie%0d_rd", i), (i % 2) ? bus.req1_read_data : bus.req0_read_data,
                  32'h1111_0000 + 32'(i));
            if (i > 0)
                check($sformatf("tie%0d_other_rd", i),
                      (i % 2) ? bus.req0_read_data : bus.req1_read_data,
                      32'h1111_0000 + 32'(i - 1));
        end
        bus.req0_start_read = 1'b0;
        bus.req1_start_read = 1'b0;

        // Single AES read, complete 3 cycles after start_read; request stale through RELEASE
        @(negedge clk);
        bus.req0_addr = 32'h40;
        bus.req0_start_read = 1'b1;
        serve(3, 32'hDEAD_BEEF, 1'b1, w, kd);
        check("single_lat", w, 1);
        check("single_k", kd, 4);
        check("single_cmpl", {bus.req1_complete, bus.req0_complete}, 2'b01);
        check("single_rd0", bus.req0_read_data, 32'hDEAD_BEEF);
        check("single_rd1", bus.req1_read_data, 32'h1111_0003);
        check("single_addr", bus.bram_addr, 32'h40);
        check("single_grant", bus.grant_id, 0);
        check("single_tout", bus.timeout_err, 0);
        @(negedge clk);
        check("single_pulse_len", bus.req0_complete, 0);
        check("release_ignores", bus.arb_busy, 0);
        bus.req0_start_read = 1'b0;

        // Twelve sequential words from 0x100
        #2;
        iss0 = issues;
        c00  = c0_cnt;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus.req0_addr = 32'h100 + 32'(4 * i);
            bus.req0_start_read = 1'b1;
            serve(1 + i % 3, 32'hA5A5_0000 + 32'(i), 1'b1, w, kd);
            check($sformatf("seq%0d_addr", i), bus.bram_addr, 32'h100 + 32'(4 * i));
            check($sformatf("seq%0d_rd", i), bus.req0_read_data, 32'hA5A5_0000 + 32'(i));
            @(negedge clk);
            bus.req0_start_read = 1'b0;
        end
        #2;
        check("seq_issues", issues - iss0, 12);
        check("seq_cmpls", c0_cnt - c00, 12);

        // No response: timeout after 8 WAIT cycles
        @(negedge clk);
        bus.req0_addr = 32'h80;
        bus.req0_start_read = 1'b1;
        serve(0, 32'h0, 1'b0, w, kd);
        check("tout_k", kd, 9);
        check("tout_flags", {bus.timeout_err, bus.req1_complete, bus.req0_complete}, 3'b101);
        check("tout_rd0", bus.req0_read_data, 0);
        check("tout_grant", bus.grant_id, 0);
        @(negedge clk);
        check("tout_pulse_len", bus.timeout_err, 0);
        bus.req0_start_read = 1'b0;

        // Completion on the timeout cycle wins
        @(negedge clk);
        bus.req0_addr = 32'h84;
        bus.req0_start_read = 1'b1;
        serve(8, 32'hC0FF_EE11, 1'b1, w, kd);
        check("coin_k", kd, 9);
        check("coin_flags", {bus.timeout_err, bus.req0_complete}, 2'b01);
        check("coin_rd0", bus.req0_read_data, 32'hC0FF_EE11);
        @(negedge clk);
        bus.req0_start_read = 1'b0;

        // Reset during WAIT, then a stray completion
        @(negedge clk);
        bus.req1_addr = 32'h200;
        bus.req1_start_read = 1'b1;
        @(negedge clk);
        check("rw_issue", bus.bram_start_read, 1);
        repeat (2) @(negedge clk);
        check("rw_grant", bus.grant_id, 1);
        check("rw_busy", bus.arb_busy, 1);
        rst_n = 1'b0;
        #1;
        check("rw_ctrl", {bus.bram_start_read, bus.arb_busy, bus.timeout_err,
                          bus.req0_complete, bus.req1_complete, bus.grant_id}, 6'b0);
        check("rw_addr", bus.bram_addr, 0);
        check("rw_rd0", bus.req0_read_data, 0);
        check("rw_rd1", bus.req1_read_data, 0);
        csum = c0_cnt + c1_cnt;
        bus.req1_start_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.bram_complete  = 1'b1;
        bus.bram_read_data = 32'h1234_5678;
        @(negedge clk);
        bus.bram_complete = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check("stray_busy", bus.arb_busy, 0);
        check("stray_cmpl", c0_cnt + c1_cnt - csum, 0);
        check("stray_rd1", bus.req1_read_data, 0);

        check("issue_total", issues, 20);
        check("cmpl_total", c0_cnt + c1_cnt, 19);
        check("cmpl_excl", excl_viol, 0);
        check("tout_total", tout_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_read_arbiter.md
BRAM_READ_ARBITER -- requirements
Module: bram_read_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, is the BRAM byte-address width.
REQ-002 Parameter DATA_W, default 32, is the BRAM read-data width.
REQ-003 Parameter TIMEOUT_CYC, default 1024, is the number of cycles to wait for bram_complete before aborting.
REQ-004 Port aes_clk, input, 1, is the single clock; all logic is rising-edge.
REQ-005 Port aes_rst_n, input, 1, is the reset: asynchronous, active-low.
REQ-006 Port req0_start_read, input, 1, is the requester-0 read request; it is held high until req0_complete.
REQ-007 Port req0_addr, input, ADDR_W, is the requester-0 address; it is stable while req0_start_read is high.
REQ-008 Port req0_complete, output, 1, is a one-cycle pulse that ends the requester-0 transaction.
REQ-009 Port req0_read_data, output, DATA_W, is the requester-0 read data; it is valid while req0_complete is high and held after.
REQ-010 Ports req1_start_read, req1_addr, req1_complete and req1_read_data SHALL be identical to the requester-0 ports for requester 1.
REQ-011 Port bram_start_read, output, 1, is the request to the shared BRAM reader.
REQ-012 Port bram_addr, output, ADDR_W, is the address to the shared BRAM reader.
REQ-013 Port bram_complete, input, 1, is the BRAM reader done strobe.
REQ-014 Port bram_read_data, input, DATA_W, is the BRAM reader data; it is valid with bram_complete.
REQ-015 Port grant_id, output, 1, is the owner of the current or last transaction.
REQ-016 Port arb_busy, output, 1, is high in any state other than IDLE.
REQ-017 Port timeout_err, output, 1, is a one-cycle pulse on an aborted transaction.

Function
REQ-018 The FSM SHALL have the states IDLE, ISSUE, WAIT and RELEASE.
REQ-019 IDLE SHALL move to ISSUE when any reqN_start_read is high, and latch the winner into grant_id and its address into bram_addr.
REQ-020 Arbitration SHALL be round-robin: a single requester wins; if both request, the requester not granted last wins; after reset, requester 0 has priority.
REQ-021 ISSUE SHALL drive bram_start_read=1 and go to WAIT on the next cycle; request-to-bram_start_read latency is 1 cycle.
REQ-022 WAIT SHALL hold bram_start_read=1 and bram_addr constant until bram_complete.
REQ-023 On bram_complete in WAIT, the arbiter SHALL register bram_read_data into the granted reqN_read_data, pulse reqN_complete for exactly 1 cycle (the next cycle), drop bram_start_read, and go to RELEASE.
REQ-024 RELEASE SHALL last exactly 1 cycle and ignore all requests, so that a stale start_read that the requester drops on seeing complete is not re-arbitrated; it then goes to IDLE.
REQ-025 The non-granted requester SHALL see no complete pulse, and its read_data SHALL be unchanged.
REQ-026 The timeout counter SHALL clear on entering ISSUE and increment each WAIT cycle; at TIMEOUT_CYC without bram_complete the arbiter SHALL pulse timeout_err and the granted reqN_complete, return read_data = 0, and go to RELEASE.
REQ-027 If bram_complete and the timeout coincide, bram_complete SHALL win with real data and no timeout_err.
REQ-028 bram_complete seen in IDLE, ISSUE or RELEASE SHALL be ignored.
REQ-029 A requester dropping start_read mid-transaction SHALL not abort the BRAM access; the transaction completes normally.
REQ-030 The complete pulses are mutually exclusive, and at most one BRAM transaction is outstanding.
REQ-031 The width of the timeout counter SHALL be clog2(TIMEOUT_CYC+1), and the counter saturates without wrap.

Reset
REQ-032 Asserting aes_rst_n low at any time, including mid-transaction, SHALL immediately force: state IDLE; bram_start_read, bram_addr, req0/1_complete, req0/1_read_data, timeout_err, arb_busy and the timeout counter all 0; grant_id 0; round-robin pointer set so requester 0 wins the first tie.
REQ-033 After reset release, the first arbitration SHALL occur on the first rising edge with a request present.

Structure
REQ-034 The shared package SHALL hold the FSM state encoding constants, the requester ID constants (REQ_AES=0, REQ_AUX=1) and the default TIMEOUT_CYC.
REQ-035 One sub-module, rr_arbiter2 (a two-way round-robin grant with last-grant pointer), SHALL be used; the rest is flat in bram_read_arbiter.

Verification
REQ-036 A single request, req0_addr=0x40 with bram_complete 3 cycles after bram_start_read and data 0xDEADBEEF, SHALL give bram_addr=0x40, req0_complete for 1 cycle, req0_read_data=0xDEADBEEF, and req1 untouched.
REQ-037 Simultaneous requests on both (addr 0x10/0x20) repeated 4 times SHALL give the grant order 0,1,0,1 with bram_addr 0x10,0x20,0x10,0x20.
REQ-038 A back-to-back AES-style sequence of 12 sequential words from 0x100 by step 4, with start_read dropped on complete, SHALL give 12 BRAM transactions with no duplicate issue in RELEASE.
REQ-039 No bram_complete with TIMEOUT_CYC=8 SHALL give timeout_err and req0_complete in the same cycle, 8 WAIT cycles after ISSUE, with req0_read_data=0.
REQ-040 Reset asserted during WAIT, followed by a stray bram_complete after release, SHALL give all outputs 0 immediately and no complete pulse.
REQ-041 bram_complete coinciding with the timeout cycle SHALL give real data returned and timeout_err=0.
